boot_loader: RTL and testbench



---
 rtl/boot_loader.sv | 99 +++++++++
 tb/tb_boot_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: framed byte stream to 32-bit instruction-memory words.
// Holds the CPU in reset until the image checksum verifies.
module boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [7:0]  cnt;
  logic [7:0]  widx;
  logic [1:0]  bidx;
  logic [31:0] shreg;
  logic [7:0]  xsum;
  logic        acc;
  logic        last;

  assign acc  = in_valid && in_ready;
  assign last = (bidx == 2'd3) && (widx == cnt);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_COUNT;
    else        state <= nxt;
  end

  // Next-state decode on accepted bytes.
  always_comb begin
    nxt = state;
    unique case (state)
      S_COUNT: if (acc) nxt = S_DATA;
      S_DATA:  if (acc && last) nxt = S_CHECK;
      S_CHECK: if (acc) nxt = (in_data == xsum) ? S_RUN : S_ERR;
      default: nxt = state;
    endcase
  end

  // Datapath and registered outputs, derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      widx       <= '0;
      bidx       <= '0;
      shreg      <= '0;
      xsum       <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      in_ready  <= (nxt == S_COUNT) || (nxt == S_DATA)
                || (nxt == S_CHECK);
      done      <= (nxt == S_RUN);
      cpu_rst_n <= (nxt == S_RUN);
      error     <= (nxt == S_ERR);
      if (acc && state == S_COUNT) begin
        cnt  <= in_data;
        widx <= '0;
        bidx <= '0;
        xsum <= '0;
      end
      if (acc && state == S_DATA) begin
        shreg <= {in_data, shreg[31:8]};
        xsum  <= xsum ^ in_data;
        bidx  <= bidx + 2'd1;
        if (bidx == 2'd3) begin
          imem_we    <= 1'b1;
          imem_addr  <= ADDR_W'(widx);
          imem_wdata <= {in_data, shreg[31:8]};
          if (widx != cnt) widx <= widx + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames against a byte-list model of the loader.
// Every cycle the DUT outputs are compared with the model.
module tb_boot_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       cpu_rst_n;
  logic       done;
  logic       error;

  int errors = 0;
  int checks = 0;

  boot_loader #(.ADDR_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  // Model: list of accepted bytes; expectations follow from frame rules.
  logic [7:0]  m_buf [0:1100];
  int          m_n;
  int          m_words;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic        m_ready;
  logic        m_done;
  logic        m_err;
  logic        m_fin;
  wire         m_acc = in_valid && m_ready;

  function automatic logic [7:0] xorsum(int k);
    logic [7:0] x = 8'h00;
    for (int i = 1; i <= k; i++) x = x ^ m_buf[i];
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_words <= 0; m_we <= 1'b0;
      m_addr <= '0; m_data <= '0; m_ready <= 1'b0;
      m_done <= 1'b0; m_err <= 1'b0; m_fin <= 1'b0;
    end else begin
      m_we <= 1'b0;
      m_ready <= !(m_fin || (m_acc && m_n > 0 && m_n > 4 * m_words));
      if (m_acc) begin
        m_buf[m_n] <= in_data;
        m_n <= m_n + 1;
        if (m_n == 0) begin
          m_words <= int'(in_data) + 1;
        end else if (m_n <= 4 * m_words) begin
          if (m_n % 4 == 0) begin
            m_we   <= 1'b1;
            m_addr <= 8'(m_n / 4 - 1);
            m_data <= {in_data, m_buf[m_n-1], m_buf[m_n-2], m_buf[m_n-3]};
          end
        end else begin
          m_fin  <= 1'b1;
          m_done <= (xorsum(4 * m_words) == in_data);
          m_err  <= (xorsum(4 * m_words) != in_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // DUT write log, used for the literal expectations.
  logic [7:0]  wlog_a [0:1023];
  logic [31:0] wlog_d [0:1023];
  int          wlog_n = 0;

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_ready);
    chk("imem_we", imem_we, m_we);
    chk("imem_addr", imem_addr, m_addr);
    chk("imem_wdata", imem_wdata, m_data);
    chk("cpu_rst_n", cpu_rst_n, m_done);
    chk("done", done, m_done);
    chk("error", error, m_err);
    if (imem_we === 1'b1 && wlog_n < 1024) begin
      wlog_a[wlog_n] = imem_addr;
      wlog_d[wlog_n] = imem_wdata;
      wlog_n++;
    end
  end

  task automatic send(input logic [7:0] b, input int lim, output bit ok);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < lim && !ok; t++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic put(input logic [7:0] b, input int gapmax);
    bit ok;
    send(b, 20, ok);
    chk("accept_timeout", 32'(ok), 32'd1);
    if (gapmax > 0) repeat ($urandom_range(0, gapmax)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame2(input logic [7:0] cs, input int gap);
    logic [7:0] f [0:8];
    f = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 9; i++) put(f[i], gap);
    put(cs, gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_cpu", cpu_rst_n, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    bit ok;

    // Reset behaviour.
    repeat (5) @(posedge clk);
    #1;
    chk("t1_ready_rst", in_ready, 1'b0);
    chk("t1_done_rst", done, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("t1_ready_pre", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("t1_ready_up", in_ready, 1'b1);
    chk("t1_nowrites", 32'(wlog_n), 32'd0);

    // Two-word load, back-to-back.
    base = wlog_n;
    frame2(8'h90, 0);
    chk("t2_done_now", done, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_nwr", 32'(wlog_n - base), 32'd2);
    chk("t2_a0", wlog_a[base], 8'h00);
    chk("t2_d0", wlog_d[base], 32'h00000013);
    chk("t2_a1", wlog_a[base+1], 8'h01);
    chk("t2_d1", wlog_d[base+1], 32'h00100093);
    chk("t2_done", done, 1'b1);
    chk("t2_cpu", cpu_rst_n, 1'b1);
    chk("t2_ready", in_ready, 1'b0);
    chk("t2_err", error, 1'b0);

    // Bad checksum.
    do_reset();
    base = wlog_n;
    frame2(8'h91, 0);
    send(8'h55, 5, ok);
    chk("t3_extra_rejected", 32'(ok), 32'd0);
    chk("t3_nwr", 32'(wlog_n - base), 32'd2);
    chk("t3_d1", wlog_d[base+1], 32'h00100093);
    chk("t3_err", error, 1'b1);
    chk("t3_cpu", cpu_rst_n, 1'b0);
    chk("t3_done", done, 1'b0);
    chk("t3_ready", in_ready, 1'b0);

    // Gapped valid.
    do_reset();
    base = wlog_n;
    frame2(8'h90, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_nwr", 32'(wlog_n - base), 32'd2);
    chk("t4_d0", wlog_d[base], 32'h00000013);
    chk("t4_d1", wlog_d[base+1], 32'h00100093);
    chk("t4_done", done, 1'b1);

    // Maximum frame: XOR of {i,i,i,i} over all i is zero.
    do_reset();
    base = wlog_n;
    put(8'hFF, 0);
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 4; j++) put(8'(i), 0);
    put(8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_nwr", 32'(wlog_n - base), 32'd256);
    chk("t5_a0", wlog_a[base], 8'h00);
    chk("t5_a80", wlog_a[base+128], 8'h80);
    chk("t5_d80", wlog_d[base+128], 32'h80808080);
    chk("t5_a255", wlog_a[base+255], 8'hFF);
    chk("t5_d255", wlog_d[base+255], 32'hFFFFFFFF);
    chk("t5_done", done, 1'b1);

    // Reset mid-frame.
    do_reset();
    base = wlog_n;
    put(8'h01, 0);
    put(8'h13, 0); put(8'h00, 0); put(8'h00, 0); put(8'h00, 0);
    put(8'h93, 0); put(8'h00, 0);
    @(posedge clk);
    #1;
    chk("t6_partial_nwr", 32'(wlog_n - base), 32'd1);
    do_reset();
    base = wlog_n;
    frame2(8'h90, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_nwr", 32'(wlog_n - base), 32'd2);
    chk("t6_a0", wlog_a[base], 8'h00);
    chk("t6_d0", wlog_d[base], 32'h00000013);
    chk("t6_d1", wlog_d[base+1], 32'h00100093);
    chk("t6_done", done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
